// File: rtl/uart_inst_loader_pkg.sv
// uart_inst_loader_pkg: rx FSM encoding and loader constants shared by the loader and its byte receiver
package uart_inst_loader_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} rx_state_t;
    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int BYTES_PER_INST = 4;
    localparam int DEF_CLKS_PER_BIT = 868;
    localparam int DEF_TIMEOUT_CLKS = 2000000;
endpackage

// File: rtl/uart_inst_loader_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 2-flop synchronizer, mid-bit sampling and break hold-off
module uart_rx_byte
    import uart_inst_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    input  logic       i_en,
    output logic       o_idle,
    output logic       o_start,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    rx_state_t r_state;
    logic r_sync1, r_sync2;
    logic [CW-1:0] r_cnt;
    logic [2:0] r_bit_idx;
    logic w_rxs;
    assign w_rxs = r_sync2;
    assign o_idle = r_state == ST_IDLE;
    assign o_start = i_en && o_idle && w_rxs != UART_IDLE_LEVEL;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= UART_IDLE_LEVEL;
            r_sync2 <= UART_IDLE_LEVEL;
            r_state <= ST_IDLE;
            r_cnt <= '0;
            r_bit_idx <= '0;
            o_byte_valid <= 1'b0;
            o_byte_data <= '0;
            o_frame_err <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            o_byte_valid <= 1'b0;
            o_frame_err <= 1'b0;
            if (!i_en) begin
                r_state <= w_rxs == UART_IDLE_LEVEL ? ST_IDLE : ST_BREAK;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_rxs != UART_IDLE_LEVEL) begin
                        r_state <= ST_START;
                        r_cnt <= '0;
                    end
                    ST_START: if (r_cnt == HALF_M1) begin
                        r_state <= w_rxs == UART_IDLE_LEVEL ? ST_IDLE : ST_DATA;
                        r_cnt <= '0;
                        r_bit_idx <= '0;
                    end else r_cnt <= r_cnt + 1'b1;
                    ST_DATA: if (r_cnt == FULL_M1) begin
                        o_byte_data <= {w_rxs, o_byte_data[7:1]};
                        r_cnt <= '0;
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) r_state <= ST_STOP;
                    end else r_cnt <= r_cnt + 1'b1;
                    ST_STOP: if (r_cnt == FULL_M1) begin
                        o_byte_valid <= w_rxs;
                        o_frame_err <= !w_rxs;
                        r_state <= w_rxs ? ST_IDLE : ST_BREAK;
                        r_cnt <= '0;
                    end else r_cnt <= r_cnt + 1'b1;
                    ST_BREAK: if (w_rxs == UART_IDLE_LEVEL) r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/uart_inst_loader.sv
// uart_inst_loader: packs little-endian UART bytes into 32-bit words for the program-ROM write port
module uart_inst_loader
    import uart_inst_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        en,
    output logic [31:0] inst,
    output logic        writeIns,
    output logic        frame_err,
    output logic [13:0] word_cnt
);
    localparam int IW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [IW-1:0] TIMEOUT = IW'(TIMEOUT_CLKS);
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_INST - 1);
    logic w_idle, w_start, w_byte_valid, w_frame_err, w_counting, w_timeout;
    logic [7:0] w_byte_data;
    logic [1:0] r_byte_idx;
    logic [23:0] r_word_buf;
    logic [IW-1:0] r_idle_cnt;
    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk(clk),
        .rst(rst),
        .i_rx(rx),
        .i_en(en),
        .o_idle(w_idle),
        .o_start(w_start),
        .o_byte_valid(w_byte_valid),
        .o_byte_data(w_byte_data),
        .o_frame_err(w_frame_err)
    );
    assign frame_err = w_frame_err;
    // a start edge in the same cycle keeps the partial word
    assign w_counting = w_idle && r_byte_idx != 2'd0 && !w_start;
    assign w_timeout = w_counting && r_idle_cnt == TIMEOUT;
    always_ff @(posedge clk) begin
        if (rst) begin
            inst <= '0;
            writeIns <= 1'b0;
            word_cnt <= '0;
            r_byte_idx <= '0;
            r_word_buf <= '0;
            r_idle_cnt <= '0;
        end else if (!en) begin
            writeIns <= 1'b0;
            r_byte_idx <= '0;
            r_idle_cnt <= '0;
        end else begin
            writeIns <= 1'b0;
            r_idle_cnt <= w_counting && !w_timeout ? r_idle_cnt + 1'b1 : '0;
            if (w_byte_valid) begin
                if (r_byte_idx == LAST_IDX) begin
                    inst <= {w_byte_data, r_word_buf};
                    writeIns <= 1'b1;
                    word_cnt <= word_cnt + 1'b1;
                    r_byte_idx <= '0;
                end else begin
                    r_word_buf[8*r_byte_idx +: 8] <= w_byte_data;
                    r_byte_idx <= r_byte_idx + 1'b1;
                end
            end else if (w_frame_err || w_timeout) r_byte_idx <= '0;
        end
    end
endmodule
